// File: rtl/csr_rmw_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : csr_rmw_if                                                 |
// | Description : Instruction, CSR-file and writeback handshakes of the CSR  |
// |               read-modify-write sequencer.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface csr_rmw_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [4:0]      rs1_uimm;
  logic [4:0]      rd;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] rs1_data;
  logic [1:0]      priv;
  logic [11:0]     csr_addr_o;
  logic            csr_rd_req;
  logic            csr_rd_ack;
  logic [XLEN-1:0] csr_rd_data;
  logic            csr_wr_req;
  logic [XLEN-1:0] csr_wr_data;
  logic            csr_wr_ack;
  logic            out_valid;
  logic            out_ready;
  logic            out_rd_we;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_illegal;

  modport slave (
    input  in_valid, funct3, rs1_uimm, rd, csr_addr, rs1_data, priv,
           csr_rd_ack, csr_rd_data, csr_wr_ack, out_ready,
    output in_ready, csr_addr_o, csr_rd_req, csr_wr_req, csr_wr_data,
           out_valid, out_rd_we, out_rd, out_data, out_illegal
  );

  modport master (
    output in_valid, funct3, rs1_uimm, rd, csr_addr, rs1_data, priv,
           csr_rd_ack, csr_rd_data, csr_wr_ack, out_ready,
    input  in_ready, csr_addr_o, csr_rd_req, csr_wr_req, csr_wr_data,
           out_valid, out_rd_we, out_rd, out_data, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/csr_rmw_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : csr_rmw_sequencer                                          |
// | Description : Multi-cycle CSR execution unit: decode, access check,      |
// |               read-modify-write on the CSR file, old value to writeback. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module csr_rmw_sequencer #(
  parameter int XLEN        = 32,
  parameter int PRIV_CHECK  = 1,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic     clk,
  input  logic     reset,
  csr_rmw_if.slave bus
);
  localparam bit             TO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((ACK_TIMEOUT != 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]      op_q;
  logic            re_q;
  logic            we_q;
  logic [4:0]      rd_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] wr_data_q;
  logic            illegal_q;
  logic            rd_we_q;

  logic [1:0]      op_d;
  logic            re_d;
  logic            we_d;
  logic            illegal_d;
  logic            timeout_d;
  logic [XLEN-1:0] src_d;

  function automatic logic [XLEN-1:0] f_rmw(input logic [1:0] op,
                                            input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] src);
    case (op)
      2'b10:   f_rmw = old | src;
      2'b11:   f_rmw = old & ~src;
      default: f_rmw = src;
    endcase
  endfunction

  // funct3[1:0] selects RW/RS/RC, funct3[2] selects the immediate form.
  always_comb begin
    op_d      = bus.funct3[1:0];
    re_d      = (op_d == 2'b01) ? (bus.rd != 5'd0) : 1'b1;
    we_d      = (op_d == 2'b01) ? 1'b1 : (bus.rs1_uimm != 5'd0);
    src_d     = bus.funct3[2] ? {{(XLEN-5){1'b0}}, bus.rs1_uimm} : bus.rs1_data;
    illegal_d = (op_d == 2'b00)
             || (we_d && (bus.csr_addr[11:10] == 2'b11))
             || ((PRIV_CHECK != 0) && (bus.priv < bus.csr_addr[9:8]));
    timeout_d = TO_EN && (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 2'b00;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= 5'd0;
      addr_q    <= 12'd0;
      src_q     <= '0;
      old_q     <= '0;
      wr_data_q <= '0;
      illegal_q <= 1'b0;
      rd_we_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q      <= op_d;
            re_q      <= re_d;
            we_q      <= we_d;
            rd_q      <= bus.rd;
            addr_q    <= bus.csr_addr;
            src_q     <= src_d;
            old_q     <= '0;
            cnt_q     <= '0;
            illegal_q <= illegal_d;
            rd_we_q   <= 1'b0;
            if (illegal_d) begin
              state_q <= S_RESP;
            end else if (re_d) begin
              state_q <= S_RD;
            end else begin
              state_q   <= S_WR;
              wr_data_q <= src_d;
            end
          end
        end
        S_RD: begin
          if (bus.csr_rd_ack) begin
            old_q <= bus.csr_rd_data;
            cnt_q <= '0;
            if (we_q) begin
              state_q   <= S_WR;
              wr_data_q <= f_rmw(op_q, bus.csr_rd_data, src_q);
            end else begin
              state_q <= S_RESP;
              rd_we_q <= (rd_q != 5'd0);
            end
          end else if (timeout_d) begin
            state_q   <= S_RESP;
            illegal_q <= 1'b1;
            rd_we_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WR: begin
          if (bus.csr_wr_ack) begin
            state_q <= S_RESP;
            rd_we_q <= re_q && (rd_q != 5'd0);
          end else if (timeout_d) begin
            state_q   <= S_RESP;
            illegal_q <= 1'b1;
            rd_we_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.csr_rd_req  = (state_q == S_RD);
  assign bus.csr_wr_req  = (state_q == S_WR);
  assign bus.out_valid   = (state_q == S_RESP);
  assign bus.csr_addr_o  = addr_q;
  assign bus.csr_wr_data = wr_data_q;
  assign bus.out_rd_we   = rd_we_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_data    = old_q;
  assign bus.out_illegal = illegal_q;
endmodule
`default_nettype wire
